// File: rtl/bus_read_unit.sv
// bus_read_unit: converts the fetch-side bus_read_vaild/bus_read_ready handshake
// into 80386-style non-pipelined external code read cycles (Ti/T1/T2, ADS#, READY#).
// One outstanding dword read at a time; no write path.
// Optional feature macro: BUS_TIMEOUT_EN (aborts a T2 wait after TIMEOUT_CYCLES).
module bus_read_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned WAIT_CNT_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      bus_read_vaild,
    input  logic [31:0]               bus_read_address,
    output logic                      bus_read_ready,
    output logic [31:0]               bus_read_data,
    output logic                      bus_error,
    output logic                      bus_busy,
    output logic [WAIT_CNT_WIDTH-1:0] wait_states,
    output logic                      ADS_n,
    output logic [29:0]               A,
    output logic [3:0]                BE_n,
    output logic                      M_IO_n,
    output logic                      D_C_n,
    output logic                      W_R_n,
    output logic                      LOCK_n,
    input  logic                      READY_n,
    input  logic [31:0]               D
);

    typedef enum logic [1:0] {
        IDLE,
        T1,
        T2,
        DONE
    } state_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WAIT_CNT_WIDTH-1:0] CNT_ONE = WAIT_CNT_WIDTH'(1);

    state_t                    state;
    state_t                    state_nx;
    logic [WAIT_CNT_WIDTH-1:0] cnt;
    logic [WAIT_CNT_WIDTH-1:0] cnt_nx;
    logic [WAIT_CNT_WIDTH-1:0] ws_nx;
    logic [29:0]               a_nx;
    logic                      ads_nx;
    logic [3:0]                be_nx;
    logic                      ready_nx;
    logic [31:0]               data_nx;
    logic                      busy_nx;
    logic                      err_nx;

    // Byte lane selection is the fetch stage's job; the low address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_read_address[1:0];

    // Cycle definition is fixed: memory, code, read, never locked.
    assign M_IO_n = 1'b1;
    assign D_C_n  = 1'b0;
    assign W_R_n  = 1'b0;
    assign LOCK_n = 1'b1;

`ifdef BUS_TIMEOUT_EN
    // Number of T2 cycles seen including the current one.
    logic [31:0] t2_seen;
    assign t2_seen = 32'(cnt) + 32'd1;
`endif

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ws_nx    = wait_states;
        a_nx     = A;
        ads_nx   = 1'b1;
        be_nx    = 4'hF;
        ready_nx = 1'b0;
        data_nx  = bus_read_data;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus_read_vaild) begin
                    a_nx     = bus_read_address[31:2];
                    ads_nx   = 1'b0;
                    be_nx    = 4'h0;
                    state_nx = T1;
                end
            end
            T1: begin
                cnt_nx   = '0;
                be_nx    = 4'h0;
                state_nx = T2;
            end
            T2: begin
                be_nx  = 4'h0;
                cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                if (!READY_n) begin
                    data_nx  = D;
                    ready_nx = 1'b1;
                    ws_nx    = cnt;
                    be_nx    = 4'hF;
                    state_nx = DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (t2_seen >= TIMEOUT_CYCLES) begin
                    data_nx  = '1;
                    ready_nx = 1'b1;
                    err_nx   = 1'b1;
                    ws_nx    = cnt;
                    be_nx    = 4'hF;
                    state_nx = DONE;
                end
`endif
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            wait_states    <= '0;
            A              <= '0;
            ADS_n          <= 1'b1;
            BE_n           <= 4'hF;
            bus_read_ready <= 1'b0;
            bus_read_data  <= '0;
            bus_busy       <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            wait_states    <= ws_nx;
            A              <= a_nx;
            ADS_n          <= ads_nx;
            BE_n           <= be_nx;
            bus_read_ready <= ready_nx;
            bus_read_data  <= data_nx;
            bus_busy       <= busy_nx;
        end
    end

`ifdef BUS_TIMEOUT_EN
    logic err_q;

    // Abort flag pulses alongside the completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nx;
        end
    end

    assign bus_error = err_q;
`else
    logic unused_err;
    assign unused_err = err_nx;
    assign bus_error  = 1'b0;
`endif

endmodule
